// File: rtl/ipg_tx_mux_if.sv
// ipg_tx_mux_if
//   Bundles the queue-side handshakes and the PCS-side block stream of the
//   transmit mux into one interface.
//   master : the mux itself. It reads the queue heads and ipg_en, and drives
//            the pops and the registered 66-bit block stream.
//   slave  : the surrounding queues, buffer monitor and PCS.
// Signals:
//   ipg_en          buffer monitor grant for IPG transmission
//   tx_ipg_data     520-bit memory reply at the memory-queue head (show-ahead)
//   memq_empty      memory queue empty
//   memq_read       pop of the memory-queue head
//   netq_outd       network-queue head payload (show-ahead)
//   netq_outc       network-queue head sync header
//   netq_empty      network queue empty
//   netq_read       pop of the network-queue head
//   encoded_tx_data registered 64-bit block payload toward the PCS
//   encoded_tx_hdr  registered 2-bit sync header
//   ipg_busy        registered, high while a burst block is on the output
//   net_underrun    registered pulse, network queue ran dry inside a frame
interface ipg_tx_mux_if;
  logic         ipg_en;
  logic [519:0] tx_ipg_data;
  logic         memq_empty;
  logic         memq_read;
  logic [63:0]  netq_outd;
  logic [1:0]   netq_outc;
  logic         netq_empty;
  logic         netq_read;
  logic [63:0]  encoded_tx_data;
  logic [1:0]   encoded_tx_hdr;
  logic         ipg_busy;
  logic         net_underrun;

  modport master (
    input  ipg_en, tx_ipg_data, memq_empty, netq_outd, netq_outc, netq_empty,
    output memq_read, netq_read, encoded_tx_data, encoded_tx_hdr, ipg_busy,
           net_underrun
  );

  modport slave (
    output ipg_en, tx_ipg_data, memq_empty, netq_outd, netq_outc, netq_empty,
    input  memq_read, netq_read, encoded_tx_data, encoded_tx_hdr, ipg_busy,
           net_underrun
  );
endinterface

// File: rtl/ipg_tx_mux.sv
// ipg_tx_mux
//   Picks one 66-bit block per cycle for the PCS scrambler/gearbox from one of
//   three sources:
//     - a network-queue block,
//     - one beat of a 520-bit memory reply sent in the inter-packet gap,
//     - an idle control block.
//   A network frame is never split. A memory reply always goes out as an
//   unbroken burst: a header block followed by 8 data blocks, MSB word first.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    ipg_tx_mux_if.master (queue heads, pops, block stream, status)
// Parameters:
//   IPG_BLOCK_TYPE   block-type byte of the burst header block
//   IDLE_BLOCK_TYPE  block-type byte of the idle block
// Build option:
//   IPG_TRAILER_EN   when defined, a control trailer {01, 64'h87} follows
//                    data beat 7, and the memory pop moves to that cycle.
module ipg_tx_mux #(
  parameter logic [7:0] IPG_BLOCK_TYPE  = 8'h0f,
  parameter logic [7:0] IDLE_BLOCK_TYPE = 8'h1e
) (
  input logic          clk,
  input logic          reset,
  ipg_tx_mux_if.master bus
);

  // State names say what the select logic is producing this cycle:
  // IPG_HDR is the cycle after the header was chosen, and it selects beat 0.
  localparam logic [1:0] NET      = 2'd0;
  localparam logic [1:0] IPG_HDR  = 2'd1;
  localparam logic [1:0] IPG_DATA = 2'd2;
`ifdef IPG_TRAILER_EN
  localparam logic [1:0] IPG_TRL  = 2'd3;
`endif

  logic [1:0]  state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        in_frame, in_frame_nxt;

  logic [1:0]  sel_hdr;
  logic [63:0] sel_data;
  logic        sel_busy, sel_underrun;
  logic        net_rd, mem_rd;

  logic [1:0]  hdr_p1;
  logic [63:0] data_p1;
  logic        busy_p1, underrun_p1;

  function automatic logic is_start(input logic [1:0] hdr, input logic [7:0] typ);
    return (hdr == 2'b01) && (typ == 8'h78 || typ == 8'h33);
  endfunction

  function automatic logic is_term(input logic [1:0] hdr, input logic [7:0] typ);
    logic t;
    case (typ)
      8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff: t = 1'b1;
      default:                                              t = 1'b0;
    endcase
    return (hdr == 2'b01) && t;
  endfunction

  function automatic logic [63:0] beat_sel(input logic [519:0] r, input logic [2:0] k);
    logic [63:0] b;
    case (k)
      3'd0:    b = r[519:456];
      3'd1:    b = r[455:392];
      3'd2:    b = r[391:328];
      3'd3:    b = r[327:264];
      3'd4:    b = r[263:200];
      3'd5:    b = r[199:136];
      3'd6:    b = r[135:72];
      default: b = r[71:8];
    endcase
    return b;
  endfunction

  // ---- stage p0: block select, pops and next-state ----
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    in_frame_nxt = in_frame;
    sel_hdr      = 2'b01;
    sel_data     = {56'h0, IDLE_BLOCK_TYPE};
    sel_busy     = 1'b0;
    sel_underrun = 1'b0;
    net_rd       = 1'b0;
    mem_rd       = 1'b0;
    case (state)
      NET: begin
        if (!in_frame && bus.ipg_en && !bus.memq_empty) begin
          sel_data  = {48'h0, bus.tx_ipg_data[7:0], IPG_BLOCK_TYPE};
          sel_busy  = 1'b1;
          cnt_nxt   = 3'd0;
          state_nxt = IPG_HDR;
        end else if (!bus.netq_empty) begin
          sel_hdr  = bus.netq_outc;
          sel_data = bus.netq_outd;
          net_rd   = 1'b1;
          if (is_start(bus.netq_outc, bus.netq_outd[7:0]))
            in_frame_nxt = 1'b1;
          else if (is_term(bus.netq_outc, bus.netq_outd[7:0]))
            in_frame_nxt = 1'b0;
        end else if (in_frame) begin
          // Queue ran dry mid-frame: pad with idle, keep the frame open.
          sel_underrun = 1'b1;
        end
      end
      IPG_HDR, IPG_DATA: begin
        sel_hdr   = 2'b10;
        sel_data  = beat_sel(bus.tx_ipg_data, cnt);
        sel_busy  = 1'b1;
        cnt_nxt   = cnt + 3'd1;
        state_nxt = IPG_DATA;
        if (cnt == 3'd7) begin
`ifdef IPG_TRAILER_EN
          state_nxt = IPG_TRL;
`else
          mem_rd    = 1'b1;
          state_nxt = NET;
`endif
        end
      end
`ifdef IPG_TRAILER_EN
      IPG_TRL: begin
        sel_data  = {56'h0, 8'h87};
        sel_busy  = 1'b1;
        mem_rd    = 1'b1;
        state_nxt = NET;
      end
`endif
      default: state_nxt = NET;
    endcase
  end

  assign bus.netq_read = net_rd;
  assign bus.memq_read = mem_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= NET;
      cnt      <= 3'd0;
      in_frame <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      in_frame <= in_frame_nxt;
    end
  end

  // ---- stage p1: registered block toward the PCS ----
  // Output registers are reset as well, so that an idle block appears
  // immediately when reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_p1      <= 2'b01;
      data_p1     <= {56'h0, IDLE_BLOCK_TYPE};
      busy_p1     <= 1'b0;
      underrun_p1 <= 1'b0;
    end else begin
      hdr_p1      <= sel_hdr;
      data_p1     <= sel_data;
      busy_p1     <= sel_busy;
      underrun_p1 <= sel_underrun;
    end
  end

  assign bus.encoded_tx_hdr  = hdr_p1;
  assign bus.encoded_tx_data = data_p1;
  assign bus.ipg_busy        = busy_p1;
  assign bus.net_underrun    = underrun_p1;

endmodule

// File: tb/tb_ipg_tx_mux.sv
module tb_ipg_tx_mux;

  typedef struct {
    logic        ie;
    logic        me;
    logic        ne;
    logic [1:0]  outc;
    logic [63:0] outd;
    logic        nrd;
    logic        mrd;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        busy;
    logic        ur;
  } vec_t;

  localparam logic [63:0] IDLE  = 64'h1e;
  localparam logic [63:0] IHDR  = 64'hff0f;
  localparam logic [63:0] BEAT0 = 64'hccccaaaaccccaaaa;
  localparam logic [63:0] ONES  = 64'hffffffffffffffff;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t tbl[$];

  ipg_tx_mux_if bus();

  ipg_tx_mux dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ie, me, ne, input logic [1:0] outc,
                              input logic [63:0] outd, input logic nrd, mrd,
                              input logic [1:0] hdr, input logic [63:0] data,
                              input logic busy, ur);
    vec_t v;
    v.ie = ie; v.me = me; v.ne = ne; v.outc = outc; v.outd = outd;
    v.nrd = nrd; v.mrd = mrd; v.hdr = hdr; v.data = data; v.busy = busy; v.ur = ur;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus.ipg_en     = v.ie;
    bus.memq_empty = v.me;
    bus.netq_empty = v.ne;
    bus.netq_outc  = v.outc;
    bus.netq_outd  = v.outd;
    #1;
    chk({tag, " netq_read"}, 64'(bus.netq_read), 64'(v.nrd));
    chk({tag, " memq_read"}, 64'(bus.memq_read), 64'(v.mrd));
    @(posedge clk);
    #1;
    chk({tag, " hdr"},      64'(bus.encoded_tx_hdr), 64'(v.hdr));
    chk({tag, " data"},     bus.encoded_tx_data,     v.data);
    chk({tag, " busy"},     64'(bus.ipg_busy),       64'(v.busy));
    chk({tag, " underrun"}, 64'(bus.net_underrun),   64'(v.ur));
  endtask

  // Beat k of the reply, header already out; ipg_en/memq_empty held active
  // and a network block waiting, all of which the burst must ignore.
  task automatic burst_beats(input string tag);
    for (int k = 0; k < 8; k++) begin
`ifdef IPG_TRAILER_EN
      apply(mk(1, 0, 0, 2'b10, 64'h5, 0, 0, 2'b10, (k == 0) ? BEAT0 : ONES, 1, 0),
            $sformatf("%s beat%0d", tag, k));
`else
      apply(mk(1, 0, 0, 2'b10, 64'h5, 0, (k == 7), 2'b10, (k == 0) ? BEAT0 : ONES, 1, 0),
            $sformatf("%s beat%0d", tag, k));
`endif
    end
`ifdef IPG_TRAILER_EN
    apply(mk(1, 0, 0, 2'b10, 64'h5, 0, 1, 2'b01, 64'h87, 1, 0), {tag, " trailer"});
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.ipg_en      = 1'b0;
    bus.memq_empty  = 1'b1;
    bus.netq_empty  = 1'b1;
    bus.netq_outc   = 2'b01;
    bus.netq_outd   = 64'h0;
    bus.tx_ipg_data = {BEAT0, {456{1'b1}}};

    repeat (2) @(posedge clk);
    #1;
    chk("reset hdr",       64'(bus.encoded_tx_hdr), 64'(2'b01));
    chk("reset data",      bus.encoded_tx_data,     IDLE);
    chk("reset busy",      64'(bus.ipg_busy),       64'h0);
    chk("reset underrun",  64'(bus.net_underrun),   64'h0);
    chk("reset netq_read", 64'(bus.netq_read),      64'h0);
    chk("reset memq_read", 64'(bus.memq_read),      64'h0);
    @(negedge clk);
    reset = 1'b1;

    //                ie me ne outc   outd                    nrd mrd hdr    data                    busy ur
    tbl.push_back(mk(0, 1, 1, 2'b01, 64'h0,                   0, 0, 2'b01, IDLE,                   0, 0));
    tbl.push_back(mk(0, 1, 1, 2'b01, 64'h0,                   0, 0, 2'b01, IDLE,                   0, 0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 64'h0011223344556678,    1, 0, 2'b01, 64'h0011223344556678,   0, 0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 64'hbb11223344556677,    1, 0, 2'b10, 64'hbb11223344556677,   0, 0));
    tbl.push_back(mk(0, 1, 1, 2'b01, 64'h0,                   0, 0, 2'b01, IDLE,                   0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b01, 64'h000000000000bb99,    1, 0, 2'b01, 64'h000000000000bb99,   0, 0));
    tbl.push_back(mk(0, 1, 1, 2'b01, 64'h0,                   0, 0, 2'b01, IDLE,                   0, 0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 64'h0000000000000078,    1, 0, 2'b01, 64'h78,                 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'b10, 64'h0102030405060708,    1, 0, 2'b10, 64'h0102030405060708,   0, 0));
    tbl.push_back(mk(1, 0, 0, 2'b01, 64'h00000000000000ff,    1, 0, 2'b01, 64'hff,                 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'b10, 64'h5,                   0, 0, 2'b01, IHDR,                   1, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));
    burst_beats("burst");
    apply(mk(0, 1, 0, 2'b10, 64'h1234, 1, 0, 2'b10, 64'h1234, 0, 0), "after burst");

    // Reset in the middle of a burst, with beat 4 on the output.
    apply(mk(1, 0, 1, 2'b01, 64'h0, 0, 0, 2'b01, IHDR, 1, 0), "rst hdr");
    for (int k = 0; k < 5; k++)
      apply(mk(1, 0, 1, 2'b01, 64'h0, 0, 0, 2'b10, (k == 0) ? BEAT0 : ONES, 1, 0),
            $sformatf("rst beat%0d", k));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst hdr",       64'(bus.encoded_tx_hdr), 64'(2'b01));
    chk("midrst data",      bus.encoded_tx_data,     IDLE);
    chk("midrst busy",      64'(bus.ipg_busy),       64'h0);
    chk("midrst memq_read", 64'(bus.memq_read),      64'h0);
    bus.ipg_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    // Entry was never popped, so the same reply restarts from its header.
    apply(mk(1, 0, 1, 2'b01, 64'h0, 0, 0, 2'b01, IHDR, 1, 0), "restart hdr");
    burst_beats("restart");
    apply(mk(0, 1, 1, 2'b01, 64'h0, 0, 0, 2'b01, IDLE, 0, 0), "final idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
